point_route_controller: RTL and testbench
=========================================

// Module: point_route_controller
// PURPOSE
// Initiator side of the linear-point command interface: it drives en/object_selection/command
// into a linear_point array and watches the returned per-object status. Accepts one route request
// (object mask + desired positions), commands each object that needs moving in ascending index order,
// waits for status confirmation with timeout and retry, then reports completion or failure.
// Sits between route-request logic and the linear_point block.
// PARAMETERS
// N_OBJ    5   number of controlled objects (matches the linear_point status width)
// SEL_W    3   width of object_selection_o; 2**SEL_W >= N_OBJ
// TIMEOUT  16  cycles to wait for status confirmation per command attempt (>=2)
// RETRIES  2   re-issues allowed after the first timeout, before abort
// PORTS
// clk_i              in   1      clock, rising edge
// rst_i              in   1      asynchronous reset, active-low
// req_valid_i        in   1      route request valid
// req_ready_o        out  1      high only in IDLE; request accepted when valid & ready
// req_mask_i         in   N_OBJ  objects participating in the route
// req_pos_i          in   N_OBJ  desired status per object (valid where mask bit set)
// en_o               out  1      command strobe to linear_point (en_i)
// object_selection_o out  SEL_W  target object index (object_selection)
// command_o          out  1      desired position driven with en_o (command_i)
// status_i           in   N_OBJ  object status from linear_point (status_o)
// busy_o             out  1      high in any state except IDLE
// done_o             out  1      one-cycle pulse when the route finishes (ok or error)
// err_o              out  1      valid with done_o: 1 = an object failed to confirm
// err_idx_o          out  SEL_W  valid with done_o & err_o: index of the failing object
// BEHAVIOUR
// - Reset (rst_i=0, async): state IDLE, idx=0, all outputs 0 except req_ready_o=1; latched mask/pos cleared.
// - FSM states: IDLE, CHECK, ISSUE, WAIT, DONE.
// - IDLE: on valid&ready, latch mask/pos, idx<=0, retry<=0, go to CHECK. A request is never accepted outside IDLE.
// - CHECK (1 cycle per index): if mask[idx]=0 or status_i[idx]==pos[idx], skip. Skip means idx++, or DONE (err=0) after idx N_OBJ-1.
//   Otherwise go to ISSUE. An empty mask yields DONE after N_OBJ CHECK cycles.
// - ISSUE (exactly 1 cycle): en_o=1, object_selection_o=idx, command_o=pos[idx]; timer cleared; then WAIT.
// - en_o is registered and high only in ISSUE. object_selection_o/command_o hold their value through WAIT; both are 0 in IDLE.
// - WAIT: timer counts 1..TIMEOUT.
//   - status_i[idx]==pos[idx] on any cycle: advance idx and go to CHECK, or DONE after the last index.
//   - Timer reaches TIMEOUT unconfirmed:
//     - if retry<RETRIES: retry++ and return to ISSUE.
//     - else: err<=1, err_idx<=idx, go to DONE (remaining objects not commanded).
//   - Confirmation on the same cycle as the timeout wins (treated as success).
//   - retry resets to 0 when idx advances.
// - DONE (1 cycle): done_o=1, err_o/err_idx_o valid; then IDLE, where err_o/err_idx_o hold until the next acceptance.
// - Latency, single object needing a move, status confirming k cycles after en_o:
//   accept at T, CHECK T+1, en_o at T+2, done_o at T+2+k+1.
// - Timer width is $clog2(TIMEOUT+1); it saturates and never wraps.
// - Reset mid-operation: immediate return to IDLE, en_o drops asynchronously, no done_o pulse.
// - status_i is used directly (linear_point outputs are registered); no extra sync stage.
// STRUCTURE
// - Package point_ctrl_pkg:
//   - state enum route_state_e {IDLE,CHECK,ISSUE,WAIT,DONE};
//   - localparams N_OBJ_DEF, SEL_W_DEF;
//   - function idx2sel.
// - Sub-module point_timeout_timer (clear, enable, expired at TIMEOUT), instanced once.
// - Top holds the FSM, index/retry counters and output registers.
// TESTING
// 1 mask=00001 pos=1, status[0]=0, status rises 3 cycles after en_o
//   -> one en_o pulse, sel=0 cmd=1, done_o=1 err_o=0.
// 2 mask=10101 pos=10101, status already 10101
//   -> no en_o pulses, done_o after 5 CHECK cycles, err_o=0.
// 3 mask=00100 pos=1, status never confirms, TIMEOUT=16 RETRIES=2
//   -> 3 en_o pulses 17 cycles apart, done_o with err_o=1 err_idx_o=2.
// 4 mask=11010 pos=01000, status obj1 stays wrong
//   -> obj1 commanded (cmd=0) and confirmed, obj3 skipped if matched,
//      obj4 cmd=0; commands issued in order 1,3,4.
// 5 rst_i=0 pulse during WAIT -> en_o/busy_o 0 immediately, req_ready_o=1,
//   no done_o; next request is processed normally.
// 6 req_valid_i held high while busy_o=1 -> req_ready_o=0 and no second acceptance
//   until the cycle after done_o.

Source files
------------

// File: rtl/point_route_controller_pkg.sv
// Shared types and defaults for the linear-point route controller slice.
// FSM state enumeration plus a helper that maps an object index onto a selection code.
package point_ctrl_pkg;

  localparam int N_OBJ_DEF = 5;
  localparam int SEL_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } route_state_e;

  // Wide result so callers can cast down to whatever selection width they use.
  function automatic logic [15:0] idx2sel(input int idx);
    return 16'(idx);
  endfunction

endpackage

// File: rtl/point_route_controller_if.sv
// Request and linear_point command/status signals of the route controller.
// master = the controller itself, slave = the route-request logic / linear_point side.
interface point_route_controller_if import point_ctrl_pkg::*; #(
  parameter int N_OBJ = N_OBJ_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [N_OBJ-1:0] req_mask_i;
  logic [N_OBJ-1:0] req_pos_i;
  logic             en_o;
  logic [SEL_W-1:0] object_selection_o;
  logic             command_o;
  logic [N_OBJ-1:0] status_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [SEL_W-1:0] err_idx_o;

  modport master (
    input  req_valid_i, req_mask_i, req_pos_i, status_i,
    output req_ready_o, en_o, object_selection_o, command_o,
           busy_o, done_o, err_o, err_idx_o
  );

  modport slave (
    output req_valid_i, req_mask_i, req_pos_i, status_i,
    input  req_ready_o, en_o, object_selection_o, command_o,
           busy_o, done_o, err_o, err_idx_o
  );

endinterface

// File: rtl/point_route_controller_timer.sv
// Per-attempt confirmation timer: counts WAIT cycles, saturates at TIMEOUT.
// o_expired flags the TIMEOUT-th enabled cycle (the elapsed count lags the cycle number by one).
module point_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TW'(TIMEOUT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/point_route_controller.sv
// Route controller: walks the requested objects in ascending order, commands those not yet
// in position, waits for status confirmation with timeout/retry and reports done/error.
module point_route_controller import point_ctrl_pkg::*; #(
  parameter int N_OBJ   = N_OBJ_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = 16,
  parameter int RETRIES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  point_route_controller_if.master bus
);

  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CHECK = CHECK;
  localparam logic [2:0] S_ISSUE = ISSUE;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [SEL_W-1:0] r_idx;
  logic [RW-1:0]    r_retry;
  logic [N_OBJ-1:0] r_mask;
  logic [N_OBJ-1:0] r_pos;
  logic             r_en;
  logic [SEL_W-1:0] r_sel;
  logic             r_cmd;
  logic             r_done;
  logic             r_err;
  logic [SEL_W-1:0] r_err_idx;

  logic w_last;
  logic w_obj_ok;
  logic w_skip;
  logic w_retry_left;
  logic w_tmo;

  assign w_last       = (r_idx == SEL_W'(idx2sel(N_OBJ - 1)));
  assign w_obj_ok     = (bus.status_i[r_idx] == r_pos[r_idx]);
  assign w_skip       = !r_mask[r_idx] || w_obj_ok;
  assign w_retry_left = (r_retry < RW'(RETRIES));

  point_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clear   (r_state == S_ISSUE),
    .i_enable  (r_state == S_WAIT),
    .o_expired (w_tmo)
  );

  // Confirmation is tested before the timeout so a same-cycle confirm counts as success.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!w_skip)     w_state_next = S_ISSUE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_obj_ok)  w_state_next = w_last ? S_DONE : S_CHECK;
        else if (w_tmo) w_state_next = w_retry_left ? S_ISSUE : S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_mask    <= '0;
      r_pos     <= '0;
      r_en      <= 1'b0;
      r_sel     <= '0;
      r_cmd     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_state <= w_state_next;
      r_en    <= (w_state_next == S_ISSUE);
      r_done  <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_mask    <= bus.req_mask_i;
            r_pos     <= bus.req_pos_i;
            r_idx     <= '0;
            r_retry   <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
          end
        end
        S_CHECK: begin
          if (w_skip) begin
            if (!w_last) r_idx <= r_idx + 1'b1;
          end else begin
            r_sel <= r_idx;
            r_cmd <= r_pos[r_idx];
          end
        end
        S_WAIT: begin
          if (w_obj_ok) begin
            r_retry <= '0;
            if (!w_last) r_idx <= r_idx + 1'b1;
          end else if (w_tmo) begin
            if (w_retry_left) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
            end
          end
        end
        S_DONE: begin
          // Command outputs return to zero for IDLE; error report keeps its value.
          r_sel <= '0;
          r_cmd <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready_o        = (r_state == S_IDLE);
  assign bus.busy_o             = (r_state != S_IDLE);
  assign bus.en_o               = r_en;
  assign bus.object_selection_o = r_sel;
  assign bus.command_o          = r_cmd;
  assign bus.done_o             = r_done;
  assign bus.err_o              = r_err;
  assign bus.err_idx_o          = r_err_idx;

endmodule

// File: tb/tb_point_route_controller.sv
// Bench for point_route_controller: directed table, random requests against a cycle-count
// model, plus reset-in-WAIT and held-valid sequences; a responder emulates linear_point.
module tb_point_route_controller;
  import point_ctrl_pkg::*;

  localparam int N_OBJ    = 5;
  localparam int SEL_W    = 3;
  localparam int TIMEOUT  = 16;
  localparam int RETRIES  = 2;
  localparam int MAX_WAIT = 400;
  localparam int N_VEC    = 9;
  localparam int N_RAND   = 40;

  typedef logic [N_OBJ-1:0][1:0] att_t;
  typedef logic [N_OBJ-1:0][4:0] dly_t;

  typedef struct {
    logic [N_OBJ-1:0] mask;
    logic [N_OBJ-1:0] pos;
    logic [N_OBJ-1:0] st;
    att_t             att;
    dly_t             dly;
    int               ncmd;
    logic [11:0]      sels;
    logic [3:0]       cmds;
    int               lat;
    int               err;
    int               err_idx;
  } vec_t;

  localparam dly_t ONES = {N_OBJ{5'd1}};

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  point_route_controller_if #(.N_OBJ(N_OBJ), .SEL_W(SEL_W)) bus ();

  point_route_controller #(
    .N_OBJ(N_OBJ), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int viol  = 0;
  int t_acc = 0;

  // Responder state: object i answers on attempt rsp_att[i] after rsp_dly[i] cycles.
  logic [N_OBJ-1:0] status;
  int   pend   [N_OBJ];
  int   en_cnt [N_OBJ];
  logic tgt    [N_OBJ];
  att_t rsp_att;
  dly_t rsp_dly;

  int obs_sel[$];
  int obs_cmd[$];
  int exp_sel[$];
  int exp_cmd[$];
  bit done_seen;
  int done_cyc;
  int obs_err;
  int obs_eidx;

  vec_t vt [N_VEC];

  function automatic att_t A(input int i, input int v);
    att_t r = '0;
    if (i >= 0) r[i] = 2'(v);
    return r;
  endfunction

  function automatic dly_t D(input int i, input int d, input dly_t base);
    dly_t r = base;
    if (i >= 0) r[i] = 5'(d);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    int s;
    @(negedge clk_i);
    cyc++;
    if (rst_i && (bus.busy_o == bus.req_ready_o)) viol++;
    if (bus.en_o) begin
      obs_sel.push_back(int'(bus.object_selection_o));
      obs_cmd.push_back(int'(bus.command_o));
    end
    if (bus.done_o && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      obs_err   = int'(bus.err_o);
      obs_eidx  = int'(bus.err_idx_o);
    end
    for (int i = 0; i < N_OBJ; i++) begin
      if (pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) status[i] = tgt[i];
      end
    end
    if (bus.en_o) begin
      s = int'(bus.object_selection_o);
      if (s < N_OBJ) begin
        en_cnt[s]++;
        if (en_cnt[s] - 1 == int'(rsp_att[s])) begin
          pend[s] = int'(rsp_dly[s]);
          tgt[s]  = bus.command_o;
        end
      end
    end
    bus.status_i = status;
  endtask

  // Reference: cost of each object from CHECK/ISSUE/WAIT rules, summed into the done cycle.
  task automatic model(input logic [N_OBJ-1:0] mask, input logic [N_OBJ-1:0] pos,
                       input logic [N_OBJ-1:0] st, input att_t att, input dly_t dly,
                       output int lat, output int err, output int eidx);
    int c;
    bit ok;
    c = 0; err = 0; eidx = 0;
    exp_sel.delete();
    exp_cmd.delete();
    for (int i = 0; i < N_OBJ && err == 0; i++) begin
      c++;
      if (mask[i] && (st[i] != pos[i])) begin
        ok = 1'b0;
        for (int a = 0; a <= RETRIES && !ok; a++) begin
          exp_sel.push_back(i);
          exp_cmd.push_back(int'(pos[i]));
          if (int'(att[i]) == a) begin
            ok = 1'b1;
            c += 1 + int'(dly[i]);
          end else begin
            c += 1 + TIMEOUT;
          end
        end
        if (!ok) begin
          err  = 1;
          eidx = i;
        end
      end
    end
    lat = c + 1;
  endtask

  task automatic start_req(input logic [N_OBJ-1:0] mask, input logic [N_OBJ-1:0] pos,
                           input logic [N_OBJ-1:0] st, input att_t att, input dly_t dly);
    obs_sel.delete();
    obs_cmd.delete();
    done_seen = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      pend[i]   = 0;
      en_cnt[i] = 0;
    end
    rsp_att = att;
    rsp_dly = dly;
    status  = st;
    tick();
    bus.req_mask_i  = mask;
    bus.req_pos_i   = pos;
    bus.req_valid_i = 1'b1;
    t_acc = cyc;
  endtask

  task automatic wait_done(input bit hold);
    for (int k = 0; k < MAX_WAIT && !done_seen; k++) begin
      tick();
      if (!hold) bus.req_valid_i = 1'b0;
    end
    if (!done_seen) $display("FAIL done_timeout: no done_o within %0d cycles", MAX_WAIT);
  endtask

  task automatic compare_req(input string name, input int lat, input int err, input int eidx);
    check({name, "_done"}, int'(done_seen), 1);
    if (done_seen) begin
      check({name, "_lat"}, done_cyc - t_acc, lat);
      check({name, "_err"}, obs_err, err);
      if (err != 0) check({name, "_err_idx"}, obs_eidx, eidx);
    end
    check({name, "_ncmd"}, obs_sel.size(), exp_sel.size());
    for (int j = 0; j < exp_sel.size() && j < obs_sel.size(); j++) begin
      check({name, "_sel"}, obs_sel[j], exp_sel[j]);
      check({name, "_cmd"}, obs_cmd[j], exp_cmd[j]);
    end
    $display("req %s: lat=%0d cmds=%0d err=%0d err_idx=%0d", name,
             done_seen ? done_cyc - t_acc : -1, obs_sel.size(), obs_err, obs_eidx);
  endtask

  initial begin
    int lat, err, eidx, t2;
    logic [N_OBJ-1:0] m, p, s;
    att_t at;
    dly_t dl;
    int r;

    bus.req_valid_i = 1'b0;
    bus.req_mask_i  = '0;
    bus.req_pos_i   = '0;
    bus.status_i    = '0;
    status          = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      pend[i] = 0; en_cnt[i] = 0; tgt[i] = 1'b0;
    end
    rsp_att = '0;
    rsp_dly = ONES;

    vt[0] = '{mask:5'b00001, pos:5'b00001, st:5'b00000, att:A(-1,0), dly:D(0,3,ONES),
              ncmd:1, sels:12'h000, cmds:4'b0001, lat:10, err:0, err_idx:0};
    vt[1] = '{mask:5'b10101, pos:5'b10101, st:5'b10101, att:A(-1,0), dly:ONES,
              ncmd:0, sels:12'h000, cmds:4'b0000, lat:6, err:0, err_idx:0};
    vt[2] = '{mask:5'b00100, pos:5'b00100, st:5'b00000, att:A(2,3), dly:ONES,
              ncmd:3, sels:12'h092, cmds:4'b0111, lat:55, err:1, err_idx:2};
    vt[3] = '{mask:5'b11010, pos:5'b01000, st:5'b10010, att:A(-1,0),
              dly:D(1,2,D(3,5,D(4,1,ONES))),
              ncmd:3, sels:12'h119, cmds:4'b0010, lat:17, err:0, err_idx:0};
    vt[4] = '{mask:5'b00010, pos:5'b00010, st:5'b00000, att:A(-1,0), dly:D(1,16,ONES),
              ncmd:1, sels:12'h001, cmds:4'b0001, lat:23, err:0, err_idx:0};
    vt[5] = '{mask:5'b10000, pos:5'b10000, st:5'b00000, att:A(4,2), dly:D(4,1,ONES),
              ncmd:3, sels:12'h124, cmds:4'b0111, lat:42, err:0, err_idx:0};
    vt[6] = '{mask:5'b11111, pos:5'b11111, st:5'b00000, att:A(0,3), dly:ONES,
              ncmd:3, sels:12'h000, cmds:4'b0111, lat:53, err:1, err_idx:0};
    vt[7] = '{mask:5'b00000, pos:5'b11111, st:5'b00000, att:A(-1,0), dly:ONES,
              ncmd:0, sels:12'h000, cmds:4'b0000, lat:6, err:0, err_idx:0};
    vt[8] = '{mask:5'b01000, pos:5'b00000, st:5'b01000, att:A(3,2), dly:D(3,16,ONES),
              ncmd:3, sels:12'h0DB, cmds:4'b0000, lat:57, err:0, err_idx:0};

    // Reset state
    tick();
    check("rst_ready", int'(bus.req_ready_o), 1);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_en", int'(bus.en_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_err", int'(bus.err_o), 0);
    check("rst_sel", int'(bus.object_selection_o), 0);
    check("rst_cmd", int'(bus.command_o), 0);
    rst_i = 1'b1;
    tick();

    // Directed table
    for (int v = 0; v < N_VEC; v++) begin
      exp_sel.delete();
      exp_cmd.delete();
      for (int j = 0; j < vt[v].ncmd; j++) begin
        exp_sel.push_back(int'(vt[v].sels[3*j +: 3]));
        exp_cmd.push_back(int'(vt[v].cmds[j]));
      end
      start_req(vt[v].mask, vt[v].pos, vt[v].st, vt[v].att, vt[v].dly);
      wait_done(1'b0);
      compare_req($sformatf("vec%0d", v), vt[v].lat, vt[v].err, vt[v].err_idx);
      tick();
      check($sformatf("vec%0d_idle_sel", v), int'(bus.object_selection_o), 0);
      if (vt[v].err != 0) check($sformatf("vec%0d_err_hold", v), int'(bus.err_o), 1);
    end

    // Reset asserted while waiting for confirmation
    start_req(5'b00001, 5'b00001, 5'b00000, A(0,3), ONES);
    for (int k = 0; k < 10 && obs_sel.size() == 0; k++) begin
      tick();
      bus.req_valid_i = 1'b0;
    end
    check("rst_wait_en_seen", obs_sel.size(), 1);
    tick();
    tick();
    #2 rst_i = 1'b0;
    #1;
    check("rst_wait_en", int'(bus.en_o), 0);
    check("rst_wait_busy", int'(bus.busy_o), 0);
    check("rst_wait_ready", int'(bus.req_ready_o), 1);
    check("rst_wait_sel", int'(bus.object_selection_o), 0);
    done_seen = 1'b0;
    tick();
    tick();
    check("rst_wait_no_done", int'(done_seen), 0);
    rst_i = 1'b1;
    tick();
    model(vt[0].mask, vt[0].pos, vt[0].st, vt[0].att, vt[0].dly, lat, err, eidx);
    start_req(vt[0].mask, vt[0].pos, vt[0].st, vt[0].att, vt[0].dly);
    wait_done(1'b0);
    compare_req("after_reset", lat, err, eidx);
    tick();

    // Valid held high through a whole route: next acceptance only after done_o
    viol = 0;
    model(5'b00001, 5'b00001, 5'b00000, A(-1,0), D(0,2,ONES), lat, err, eidx);
    start_req(5'b00001, 5'b00001, 5'b00000, A(-1,0), D(0,2,ONES));
    wait_done(1'b1);
    compare_req("hold_first", lat, err, eidx);
    check("hold_done_busy", int'(bus.busy_o), 1);
    tick();
    t2 = cyc;
    check("hold_idle_ready", int'(bus.req_ready_o), 1);
    done_seen = 1'b0;
    obs_sel.delete();
    obs_cmd.delete();
    tick();
    check("hold_second_accept", int'(bus.busy_o), 1);
    bus.req_valid_i = 1'b0;
    for (int k = 0; k < MAX_WAIT && !done_seen; k++) tick();
    check("hold_second_done", int'(done_seen), 1);
    check("hold_second_lat", done_cyc - t2, 6);
    check("hold_second_ncmd", obs_sel.size(), 0);
    check("ready_busy_exclusive", viol, 0);
    tick();

    // Random requests against the model
    for (int n = 0; n < N_RAND; n++) begin
      m = N_OBJ'($urandom);
      p = N_OBJ'($urandom);
      s = N_OBJ'($urandom);
      for (int i = 0; i < N_OBJ; i++) begin
        r = int'($urandom_range(0, 9));
        at[i] = (r <= 5) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7) ? 2'd2 : 2'd3;
        dl[i] = 5'($urandom_range(1, TIMEOUT));
      end
      model(m, p, s, at, dl, lat, err, eidx);
      start_req(m, p, s, at, dl);
      wait_done(1'b0);
      compare_req($sformatf("rand%0d", n), lat, err, eidx);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
